// File: rtl/reset_pkg.sv
// rtl/reset_pkg.sv - shared state encoding and width helper for the reset sequencer
package reset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GAP   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_t;

    // Bits needed to index 'value' items, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - reset synchroniser, asynchronous assert and synchronous release
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_async,
    output logic rst_sync
);

    logic [STAGES-1:0] sync_q;

    // Assert all flops at once; release ripples a zero through the chain.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered per-stage reset release with ready handshake and timeout
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int N_STAGES       = 4,
    parameter int W              = 16,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  hw_reset,
    input  logic [N_STAGES-1:0]                   stage_ready,
    output logic [N_STAGES-1:0]                   stage_rst,
    output logic                                  sys_ready,
    output logic                                  timeout_err,
    output logic [clog2_min1(N_STAGES)-1:0]       fault_stage
);

    localparam int             KW       = clog2_min1(N_STAGES);
    localparam logic [W-1:0]   GAP_LAST = W'(GAP_CYCLES - 1);
    localparam logic [W-1:0]   TO_LAST  = W'(TIMEOUT_CYCLES - 1);
    localparam logic [KW-1:0]  K_LAST   = KW'(N_STAGES - 1);

    logic                rst_s;

    seq_state_t          state_q, state_d;
    logic [W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                sys_ready_q, sys_ready_d;
    logic                timeout_err_q, timeout_err_d;
    logic [KW-1:0]       fault_stage_q, fault_stage_d;

    reset_sync #(
        .STAGES    (2)
    ) u_reset_sync (
        .clk       (clk),
        .rst_async (hw_reset),
        .rst_sync  (rst_s)
    );

    // State, counters and registered outputs; everything is cleared by the synchronised reset.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q       <= ST_IDLE;
            gap_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            k_q           <= '0;
            stage_rst_q   <= '1;
            sys_ready_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            k_q           <= k_d;
            stage_rst_q   <= stage_rst_d;
            sys_ready_q   <= sys_ready_d;
            timeout_err_q <= timeout_err_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    // Next-state logic: gap before each release, then wait for that stage's ready or time out.
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        k_d           = k_q;
        stage_rst_d   = stage_rst_q;
        sys_ready_d   = sys_ready_q;
        timeout_err_d = timeout_err_q;
        fault_stage_d = fault_stage_q;

        case (state_q)
            ST_IDLE: begin
                gap_cnt_d = '0;
                k_d       = '0;
                state_d   = ST_GAP;
            end

            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + W'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    // Only ever clear bits here, so earlier stages stay released.
                    stage_rst_d[k_q] = 1'b0;
                    wait_cnt_d       = '0;
                    state_d          = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Ready is checked before the timeout so a late-but-on-time stage still passes.
                if (stage_ready[k_q]) begin
                    if (k_q == K_LAST) begin
                        sys_ready_d = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        k_d       = k_q + KW'(1);
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    stage_rst_d   = '1;
                    sys_ready_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    fault_stage_d = k_q;
                    state_d       = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + W'(1);
                end
            end

            ST_RUN: begin
                stage_rst_d = '0;
                sys_ready_d = 1'b1;
            end

            ST_FAULT: begin
                stage_rst_d = '1;
                sys_ready_d = 1'b0;
            end

            default: begin
                // Unreachable encodings fall back to a full reset of the sequence.
                stage_rst_d = '1;
                sys_ready_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign stage_rst   = stage_rst_q;
    assign sys_ready   = sys_ready_q;
    assign timeout_err = timeout_err_q;
    assign fault_stage = fault_stage_q;

endmodule
